// File: rtl/uart_pkg.sv
// Constants shared by the UART receiver, transmitter and receive buffer,
// plus the receive-buffer entry layout.
package uart_pkg;

  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_EVEN = 2'd1;
  localparam logic [1:0] PARITY_ODD  = 2'd2;

  localparam logic [1:0] DATA_NUM_5 = 2'd0;
  localparam logic [1:0] DATA_NUM_6 = 2'd1;
  localparam logic [1:0] DATA_NUM_7 = 2'd2;
  localparam logic [1:0] DATA_NUM_8 = 2'd3;

  localparam logic STOP_NUM_1 = 1'b0;
  localparam logic STOP_NUM_2 = 1'b1;

  localparam int UART_RX_FIFO_DEPTH = 16;

  typedef struct packed {
    logic       perr;
    logic [7:0] data;
  } uart_rx_entry_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// Receive-buffer storage: DEPTH entries, synchronous write, asynchronous read
// so the head entry falls through to the output port without a read cycle.
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RX_FIFO_DEPTH,
  parameter int AW    = 4
) (
  input  logic           clk_i,
  input  logic           we_i,
  input  logic [AW-1:0]  waddr_i,
  input  uart_rx_entry_t wdata_i,
  input  logic [AW-1:0]  raddr_i,
  output uart_rx_entry_t rdata_o
);

  uart_rx_entry_t mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures received characters into a FWFT FIFO with level,
// threshold and overrun status. Define UART_RX_FIFO_TIMEOUT_EN for the idle-timeout interrupt.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RX_FIFO_DEPTH,
  parameter int AW    = 4
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic [7:0]    data_rx_i,
  input  logic          datarx_vld_i,
  input  logic          int_parity_error_i,
  input  logic          clk_sample_i,
  output logic [7:0]    rx_data_o,
  output logic          rx_perr_o,
  output logic          rx_vld_o,
  input  logic          rx_rdy_i,
  input  logic          flush_i,
  input  logic          clr_err_i,
  input  logic [AW:0]   thresh_i,
  output logic [AW:0]   level_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          overrun_o,
`ifdef UART_RX_FIFO_TIMEOUT_EN
  input  logic [15:0]   timeout_ticks_i,
  output logic          int_timeout_o,
`endif
  output logic          int_thresh_o
);

  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    level, level_nxt;
  logic           full, empty, push, pop, drop;
  uart_rx_entry_t wr_entry, rd_entry;

  // Output handshake: rx_vld_o holds while entries exist; the head entry is
  // consumed on any edge where rx_vld_o & rx_rdy_i, and is stable until then.
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign pop   = !empty & rx_rdy_i;
  assign push  = datarx_vld_i & (!full | pop);
  assign drop  = datarx_vld_i & full & !pop;

  always_comb begin
    level_nxt = level;
    if (flush_i)           level_nxt = '0;
    else if (push && !pop) level_nxt = level + (AW+1)'(1);
    else if (pop && !push) level_nxt = level - (AW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      overrun_o    <= 1'b0;
      int_thresh_o <= 1'b0;
    end else begin
      level        <= level_nxt;
      int_thresh_o <= (level_nxt >= thresh_i) && (thresh_i != '0);
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      // A drop in the same cycle as a clear must leave the flag set.
      if (drop)           overrun_o <= 1'b1;
      else if (clr_err_i) overrun_o <= 1'b0;
    end
  end

  assign wr_entry = '{perr: int_parity_error_i, data: data_rx_i};

  uart_fifo_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk_i   (clk_i),
    .we_i    (push & !flush_i),
    .waddr_i (wr_ptr),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr),
    .rdata_o (rd_entry)
  );

  assign rx_data_o = rd_entry.data;
  assign rx_perr_o = rd_entry.perr;
  assign rx_vld_o  = !empty;
  assign level_o   = level;
  assign full_o    = full;
  assign empty_o   = empty;

`ifdef UART_RX_FIFO_TIMEOUT_EN
  logic [15:0] to_cnt, to_cnt_nxt;

  // Counts oversample ticks spent holding data with no traffic in either direction.
  always_comb begin
    to_cnt_nxt = to_cnt;
    if (push || pop || flush_i)     to_cnt_nxt = '0;
    else if (clk_sample_i && !empty) to_cnt_nxt = to_cnt + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      to_cnt        <= '0;
      int_timeout_o <= 1'b0;
    end else begin
      to_cnt <= to_cnt_nxt;
      if (pop || flush_i)
        int_timeout_o <= 1'b0;
      else if ((timeout_ticks_i != '0) && (to_cnt_nxt == timeout_ticks_i))
        int_timeout_o <= 1'b1;
    end
  end
`else
  logic unused_sample;
  assign unused_sample = clk_sample_i;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Table-driven bench for uart_rx_fifo: per-cycle vectors with expected status,
// and a queue scoreboard for the characters leaving the FIFO.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic [7:0]    data_rx_i;
  logic          datarx_vld_i;
  logic          int_parity_error_i;
  logic          clk_sample_i;
  logic [7:0]    rx_data_o;
  logic          rx_perr_o;
  logic          rx_vld_o;
  logic          rx_rdy_i;
  logic          flush_i;
  logic          clr_err_i;
  logic [AW:0]   thresh_i;
  logic [AW:0]   level_o;
  logic          full_o;
  logic          empty_o;
  logic          overrun_o;
  logic          int_thresh_o;
`ifdef UART_RX_FIFO_TIMEOUT_EN
  logic [15:0]   timeout_ticks_i;
  logic          int_timeout_o;
`endif

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i              (clk_i),
    .reset_n_i          (reset_n_i),
    .data_rx_i          (data_rx_i),
    .datarx_vld_i       (datarx_vld_i),
    .int_parity_error_i (int_parity_error_i),
    .clk_sample_i       (clk_sample_i),
    .rx_data_o          (rx_data_o),
    .rx_perr_o          (rx_perr_o),
    .rx_vld_o           (rx_vld_o),
    .rx_rdy_i           (rx_rdy_i),
    .flush_i            (flush_i),
    .clr_err_i          (clr_err_i),
    .thresh_i           (thresh_i),
    .level_o            (level_o),
    .full_o             (full_o),
    .empty_o            (empty_o),
    .overrun_o          (overrun_o),
`ifdef UART_RX_FIFO_TIMEOUT_EN
    .timeout_ticks_i    (timeout_ticks_i),
    .int_timeout_o      (int_timeout_o),
`endif
    .int_thresh_o       (int_thresh_o)
  );

  // Clock
  always #5 clk_i = ~clk_i;

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        p;
    logic        r;
    logic        f;
    logic        c;
    logic [AW:0] thr;
    logic        acc;
    logic [AW:0] lvl;
    logic        ovr;
    logic        ithr;
  } vec_t;

  vec_t       vecs[$];
  logic [8:0] exp_q[$];
  int         total = 0;
  int         bad   = 0;
  int         cur   = -1;

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic p,
                              input logic r, input logic f, input logic c,
                              input logic [AW:0] thr, input logic acc,
                              input logic [AW:0] lvl, input logic ovr, input logic ithr);
    vec_t t;
    t.v = v; t.d = d; t.p = p; t.r = r; t.f = f; t.c = c; t.thr = thr;
    t.acc = acc; t.lvl = lvl; t.ovr = ovr; t.ithr = ithr;
    return t;
  endfunction

  task automatic add(input logic v, input logic [7:0] d, input logic p, input logic r,
                     input logic f, input logic c, input logic [AW:0] thr, input logic acc,
                     input logic [AW:0] lvl, input logic ovr, input logic ithr);
    vecs.push_back(mk(v, d, p, r, f, c, thr, acc, lvl, ovr, ithr));
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (step %0d): got %0h expected %0h", nm, cur, act, exp);
    end
  endtask

  // Driver: one cycle of stimulus, scoreboard at negedge, status checked after the edge.
  task automatic apply(input vec_t t);
    logic [8:0] e;
    datarx_vld_i       = t.v;
    data_rx_i          = t.d;
    int_parity_error_i = t.p;
    rx_rdy_i           = t.r;
    flush_i            = t.f;
    clr_err_i          = t.c;
    thresh_i           = t.thr;
    @(negedge clk_i);
    if (t.f) begin
      exp_q.delete();
    end else begin
      if (rx_vld_o && t.r) begin
        if (exp_q.size() == 0) check("unexpected_pop", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("pop_data", {rx_perr_o, rx_data_o}, e);
        end
      end else if (rx_vld_o && exp_q.size() != 0) begin
        check("head_data", {rx_perr_o, rx_data_o}, exp_q[0]);
      end
      if (t.acc) exp_q.push_back({t.p, t.d});
    end
    @(posedge clk_i);
    #1;
    check("level",      level_o,      t.lvl);
    check("empty",      empty_o,      t.lvl == 0);
    check("full",       full_o,       t.lvl == DEPTH);
    check("rx_vld",     rx_vld_o,     t.lvl != 0);
    check("overrun",    overrun_o,    t.ovr);
    check("int_thresh", int_thresh_o, t.ithr);
    cur++;
  endtask

  initial begin
    // Stimulus table
    // 1: three writes, then three pops in order
    add(1, 8'h41, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    add(1, 8'h42, 0, 0, 0, 0, 0, 1, 2, 0, 0);
    add(1, 8'h43, 0, 0, 0, 0, 0, 1, 3, 0, 0);
    add(0, 8'h00, 0, 1, 0, 0, 0, 0, 2, 0, 0);
    add(0, 8'h00, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    add(0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    // 2: parity tag follows its character
    add(1, 8'h55, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    add(1, 8'h56, 0, 0, 0, 0, 0, 1, 2, 0, 0);
    add(0, 8'h00, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    add(0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    // 3: fill, overflow, overflow with clear (set wins), then clear
    for (int i = 0; i < DEPTH; i++)
      add(1, 8'(8'h60 + i), 1'(i % 2), 0, 0, 0, 0, 1, 5'(i + 1), 0, 0);
    add(1, 8'h70, 0, 0, 0, 0, 0, 0, 16, 1, 0);
    add(1, 8'h71, 0, 0, 0, 1, 0, 0, 16, 1, 0);
    add(0, 8'h00, 0, 0, 0, 1, 0, 0, 16, 0, 0);
    // 4: push and pop while full, then drain; 0x99 comes out last
    add(1, 8'h99, 0, 1, 0, 0, 0, 1, 16, 0, 0);
    for (int i = 0; i < DEPTH; i++)
      add(0, 8'h00, 0, 1, 0, 0, 0, 0, 5'(15 - i), 0, 0);
    // 5: threshold 4, then flush with a coincident write
    add(1, 8'ha0, 0, 0, 0, 0, 4, 1, 1, 0, 0);
    add(1, 8'ha1, 0, 0, 0, 0, 4, 1, 2, 0, 0);
    add(1, 8'ha2, 0, 0, 0, 0, 4, 1, 3, 0, 0);
    add(1, 8'ha3, 1, 0, 0, 0, 4, 1, 4, 0, 1);
    add(0, 8'h00, 0, 1, 0, 0, 4, 0, 3, 0, 0);
    add(1, 8'ha4, 0, 0, 0, 0, 4, 1, 4, 0, 1);
    add(1, 8'ha5, 0, 0, 0, 0, 4, 1, 5, 0, 1);
    add(1, 8'ha6, 0, 0, 1, 0, 4, 0, 0, 0, 0);
    add(0, 8'h00, 0, 1, 0, 0, 4, 0, 0, 0, 0);
    // parity pulse without a strobe is ignored
    add(0, 8'hee, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset, with a strobe in flight
    reset_n_i = 1'b0;
    datarx_vld_i = 1'b1; data_rx_i = 8'h11; int_parity_error_i = 1'b0;
    clk_sample_i = 1'b0; rx_rdy_i = 1'b0; flush_i = 1'b0; clr_err_i = 1'b0; thresh_i = '0;
`ifdef UART_RX_FIFO_TIMEOUT_EN
    timeout_ticks_i = 16'd0;
`endif
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_level",      level_o,      0);
    check("rst_empty",      empty_o,      1);
    check("rst_full",       full_o,       0);
    check("rst_vld",        rx_vld_o,     0);
    check("rst_overrun",    overrun_o,    0);
    check("rst_int_thresh", int_thresh_o, 0);
`ifdef UART_RX_FIFO_TIMEOUT_EN
    check("rst_int_timeout", int_timeout_o, 0);
`endif
    reset_n_i = 1'b1;
    cur = 0;

    foreach (vecs[i]) apply(vecs[i]);

    // Reset mid-stream discards contents and a coincident strobe
    apply(mk(1, 8'hb0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    apply(mk(1, 8'hb1, 0, 0, 0, 0, 0, 1, 2, 0, 0));
    reset_n_i = 1'b0;
    datarx_vld_i = 1'b1; data_rx_i = 8'hb2;
    @(posedge clk_i);
    #1;
    check("midrst_level", level_o,  0);
    check("midrst_vld",   rx_vld_o, 0);
    reset_n_i = 1'b1;
    exp_q.delete();
    apply(mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(1, 8'hc5, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    apply(mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 0));

`ifdef UART_RX_FIFO_TIMEOUT_EN
    // Idle timeout after eight oversample ticks, cleared by a pop
    timeout_ticks_i = 16'd8;
    apply(mk(1, 8'h3c, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    check("timeout_after_push", int_timeout_o, 0);
    for (int t = 1; t <= 8; t++) begin
      clk_sample_i = 1'b1;
      apply(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      clk_sample_i = 1'b0;
      check("timeout_tick", int_timeout_o, t == 8);
      apply(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      check("timeout_hold", int_timeout_o, t == 8);
    end
    apply(mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    check("timeout_pop_clear", int_timeout_o, 0);
`endif

    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
